// File: rtl/zstd_frame_sequencer.sv
// Zstandard frame controller: runs the header parser, walks block headers,
// routes block payload bytes downstream and collects the optional checksum.
module zstd_frame_sequencer #(
  parameter int unsigned MAX_BLOCK_SIZE = 131072,
  parameter int unsigned HDR_TIMEOUT    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        hp_start,
  output logic [15:0] hp_data,
  input  logic        hp_finished,
  input  logic [7:0]  hp_hdr_len,
  input  logic [7:0]  hp_fhd,
  input  logic [7:0]  hp_extra_byte,
  output logic        blk_valid,
  input  logic        blk_ready,
  output logic        blk_last,
  output logic [1:0]  blk_type,
  output logic [20:0] blk_size,
  output logic        pay_valid,
  output logic [7:0]  pay_data,
  input  logic        pay_ready,
  output logic [31:0] chk_value,
  output logic        chk_valid,
  output logic        frame_done,
  output logic        err,
  output logic [2:0]  err_code
);

  localparam int unsigned TW = $clog2(HDR_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, HDR, BLK_HDR, BLK_ISSUE, PAYLOAD, CHKSUM, DONE, ERROR
  } state_t;

  state_t      state, state_next, blk_end;
  logic [2:0]  code_next;
  logic        pend_flag;
  logic [7:0]  pend_byte;
  logic [7:0]  word_cnt;
  logic [TW-1:0] tick_cnt;
  logic [1:0]  byte_idx;
  logic [7:0]  b0, b1;
  logic [20:0] remain;
  logic        cks_flag;

  logic [7:0]  cur_byte;
  logic        avail, byte_want, byte_take, hdr_acc, hdr_ok;
  logic [23:0] hdr24;
  logic [8:0]  need_words;
  logic        unused;

  // Byte aligner view: a pending high byte always goes before the next word
  assign cur_byte   = pend_flag ? pend_byte : in_data[7:0];
  assign avail      = pend_flag | in_valid;
  assign byte_take  = byte_want & avail;
  assign hdr24      = {cur_byte, b1, b0};
  assign need_words = (9'(hp_hdr_len) + 9'd1) >> 1;
  assign hdr_ok     = (9'(word_cnt) == need_words);
  assign hdr_acc    = (state == HDR) & in_valid & ~hp_finished;
  assign blk_end    = !blk_last ? BLK_HDR : (cks_flag ? CHKSUM : DONE);
  assign unused     = ^{hp_fhd[7:3], hp_fhd[1:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    code_next  = 3'd0;
    unique case (state)
      IDLE: if (in_valid) state_next = HDR;
      HDR: begin
        if (hp_finished) begin
          if (hdr_ok) state_next = BLK_HDR;
          else begin state_next = ERROR; code_next = 3'd4; end
        end else if (!in_valid) begin
          state_next = ERROR; code_next = 3'd1;
        end else if (tick_cnt == TW'(HDR_TIMEOUT - 1)) begin
          state_next = ERROR; code_next = 3'd5;
        end
      end
      BLK_HDR: begin
        if (byte_take && byte_idx == 2'd2) begin
          if (hdr24[2:1] == 2'd3) begin
            state_next = ERROR; code_next = 3'd2;
          end else if (32'(hdr24[23:3]) > MAX_BLOCK_SIZE) begin
            state_next = ERROR; code_next = 3'd3;
          end else begin
            state_next = BLK_ISSUE;
          end
        end
      end
      BLK_ISSUE: begin
        if (blk_ready) begin
          if (blk_size == 21'd0 && blk_type != 2'd1) state_next = blk_end;
          else                                       state_next = PAYLOAD;
        end
      end
      PAYLOAD: if (byte_take && remain == 21'd1) state_next = blk_end;
      CHKSUM:  if (byte_take && byte_idx == 2'd3) state_next = DONE;
      DONE:    state_next = IDLE;
      ERROR:   state_next = ERROR;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    byte_want  = 1'b0;
    in_ready   = 1'b0;
    hp_start   = 1'b0;
    hp_data    = 16'd0;
    blk_valid  = 1'b0;
    pay_valid  = 1'b0;
    pay_data   = 8'd0;
    frame_done = 1'b0;
    chk_valid  = 1'b0;
    err        = 1'b0;
    unique case (state)
      HDR: begin
        in_ready = ~hp_finished;
        hp_data  = in_data;
        hp_start = hdr_acc & (word_cnt == 8'd0);
      end
      BLK_HDR, CHKSUM: begin
        byte_want = 1'b1;
        in_ready  = ~pend_flag;
      end
      BLK_ISSUE: blk_valid = 1'b1;
      PAYLOAD: begin
        byte_want = pay_ready;
        in_ready  = ~pend_flag & pay_ready;
        pay_valid = avail;
        pay_data  = cur_byte;
      end
      DONE: begin
        frame_done = 1'b1;
        chk_valid  = cks_flag;
      end
      ERROR:   err = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_flag <= 1'b0;
      pend_byte <= 8'd0;
      word_cnt  <= 8'd0;
      tick_cnt  <= '0;
      byte_idx  <= 2'd0;
      b0        <= 8'd0;
      b1        <= 8'd0;
      remain    <= 21'd0;
      cks_flag  <= 1'b0;
      blk_last  <= 1'b0;
      blk_type  <= 2'd0;
      blk_size  <= 21'd0;
      chk_value <= 32'd0;
      err_code  <= 3'd0;
    end else begin
      // Frames start word-aligned, so a leftover byte is dropped at DONE
      if (state == DONE) begin
        pend_flag <= 1'b0;
      end else if (state == HDR && state_next == BLK_HDR) begin
        pend_flag <= hp_hdr_len[0];
        pend_byte <= hp_extra_byte;
      end else if (byte_take) begin
        if (pend_flag) begin
          pend_flag <= 1'b0;
        end else begin
          pend_flag <= 1'b1;
          pend_byte <= in_data[15:8];
        end
      end

      if (state == IDLE) begin
        word_cnt <= 8'd0;
        tick_cnt <= '0;
        byte_idx <= 2'd0;
      end else if (state == HDR) begin
        tick_cnt <= tick_cnt + 1'b1;
        if (hdr_acc)     word_cnt <= word_cnt + 8'd1;
        if (hp_finished) cks_flag <= hp_fhd[2];
      end

      if (state == BLK_HDR && byte_take) begin
        unique case (byte_idx)
          2'd0: b0 <= cur_byte;
          2'd1: b1 <= cur_byte;
          default: begin
            blk_last <= hdr24[0];
            blk_type <= hdr24[2:1];
            blk_size <= hdr24[23:3];
          end
        endcase
        byte_idx <= (byte_idx == 2'd2) ? 2'd0 : byte_idx + 2'd1;
      end

      if (state == CHKSUM && byte_take) begin
        chk_value[{byte_idx, 3'b000} +: 8] <= cur_byte;
        byte_idx <= byte_idx + 2'd1;
      end

      // RLE blocks carry a single byte regardless of Block_Size
      if (state == BLK_ISSUE && blk_ready)
        remain <= (blk_type == 2'd1) ? 21'd1 : blk_size;
      else if (state == PAYLOAD && byte_take)
        remain <= remain - 21'd1;

      if (state != ERROR && state_next == ERROR) err_code <= code_next;
    end
  end

endmodule

// File: tb/tb_zstd_frame_sequencer.sv
// Randomized bench for zstd_frame_sequencer: frames are described as blocks,
// turned into a byte stream, and outputs are checked against expected queues.
module tb_zstd_frame_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready, hp_start, hp_finished;
  logic [15:0] in_data, hp_data;
  logic [7:0]  hp_hdr_len, hp_fhd, hp_extra_byte, pay_data;
  logic        blk_valid, blk_ready, blk_last, pay_valid, pay_ready;
  logic [1:0]  blk_type;
  logic [20:0] blk_size;
  logic [31:0] chk_value;
  logic        chk_valid, frame_done, err;
  logic [2:0]  err_code;

  zstd_frame_sequencer dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .hp_start(hp_start), .hp_data(hp_data), .hp_finished(hp_finished),
    .hp_hdr_len(hp_hdr_len), .hp_fhd(hp_fhd), .hp_extra_byte(hp_extra_byte),
    .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_last(blk_last),
    .blk_type(blk_type), .blk_size(blk_size),
    .pay_valid(pay_valid), .pay_data(pay_data), .pay_ready(pay_ready),
    .chk_value(chk_value), .chk_valid(chk_valid), .frame_done(frame_done),
    .err(err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  strm[$];
  logic [23:0] exp_desc[$];
  logic [7:0]  exp_pay[$];
  logic [31:0] exp_chk, last_chk;
  int          cur_hl;
  bit          cur_ck;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0; in_data = 16'd0; hp_finished = 1'b0;
    hp_hdr_len = 8'd0; hp_fhd = 8'd0; hp_extra_byte = 8'd0;
    blk_ready = 1'b0; pay_ready = 1'b0;
    last_chk = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic begin_frame(input int hl, input bit ck);
    logic [31:0] magic;
    logic [7:0]  b;
    magic = 32'hFD2FB528;
    strm.delete(); exp_desc.delete(); exp_pay.delete();
    cur_hl = hl; cur_ck = ck;
    for (int i = 0; i < hl; i++) begin
      b = 8'($urandom);
      if (i < 4) b = magic[8*i +: 8];
      if (i == 4) b = ck ? 8'h04 : 8'h00;
      strm.push_back(b);
    end
  endtask

  // base < 0 gives random payload bytes, otherwise base + i*step
  task automatic add_block(input int t, input int sz, input bit last, input int base, input int step);
    logic [23:0] h;
    logic [7:0]  b;
    int          nb;
    h = {21'(sz), 2'(t), last};
    for (int i = 0; i < 3; i++) strm.push_back(h[8*i +: 8]);
    if (t == 3 || sz > 131072) return;
    exp_desc.push_back({last, 2'(t), 21'(sz)});
    nb = (t == 1) ? 1 : sz;
    for (int i = 0; i < nb; i++) begin
      b = (base < 0) ? 8'($urandom) : 8'(base + i * step);
      strm.push_back(b);
      exp_pay.push_back(b);
    end
  endtask

  task automatic end_frame(input logic [31:0] cv, input bit rnd);
    logic [31:0] v;
    if (cur_ck) begin
      v = rnd ? 32'($urandom) : cv;
      for (int i = 0; i < 4; i++) strm.push_back(v[8*i +: 8]);
      exp_chk = v;
    end
    if (strm.size() % 2 == 1) strm.push_back(8'h00);
  endtask

  // Plays the stream and acts as header_parser and downstream sinks
  task automatic run_frame(input int exp_err, input bit no_finish, input int drop_at,
                           input bit fin_early, input bit toggle_pay, input bit gaps,
                           input int exp_err_cyc);
    int need, nwords, wi, hs_cnt, err_cyc;
    bit hdr_busy, dropped, fin, hs, done_seen, stop;
    need = (cur_hl + 1) / 2 - (fin_early ? 1 : 0);
    nwords = strm.size() / 2;
    wi = 0; hs_cnt = 0; err_cyc = -1;
    hdr_busy = 1'b1; dropped = 1'b0; done_seen = 1'b0; stop = 1'b0;
    hp_hdr_len = 8'(cur_hl);
    hp_fhd = strm[4];
    hp_extra_byte = (cur_hl % 2 == 1) ? strm[cur_hl] : 8'h00;
    for (int cyc = 0; cyc < 4000 && !stop; cyc++) begin
      @(negedge clk);
      fin = hdr_busy && !no_finish && (wi == need);
      hp_finished = fin;
      if (hdr_busy) begin
        in_valid = !(wi == drop_at && !dropped);
        if (!in_valid) dropped = 1'b1;
      end else begin
        in_valid = (wi < nwords) && !(gaps && $urandom_range(3) == 0);
      end
      in_data = (wi < nwords) ? {strm[2*wi+1], strm[2*wi]} : 16'h0000;
      blk_ready = ($urandom_range(3) != 0);
      pay_ready = toggle_pay ? (cyc % 2 == 0) : ($urandom_range(9) < 7);
      #1;
      hs = in_valid && in_ready;
      if (hp_start) begin
        hs_cnt++;
        check_eq("hp_data", 64'(hp_data), 64'({strm[1], strm[0]}));
      end
      if (blk_valid && blk_ready) begin
        if (exp_desc.size() == 0) check_eq("desc_extra", 64'd1, 64'd0);
        else check_eq("desc", 64'({blk_last, blk_type, blk_size}), 64'(exp_desc.pop_front()));
      end
      if (pay_valid && pay_ready) begin
        if (exp_pay.size() == 0) check_eq("pay_extra", 64'd1, 64'd0);
        else check_eq("pay", 64'(pay_data), 64'(exp_pay.pop_front()));
      end
      if (frame_done) begin
        done_seen = 1'b1;
        check_eq("chk_valid", 64'(chk_valid), 64'(cur_ck));
        check_eq("chk_value", 64'(chk_value), 64'(cur_ck ? exp_chk : last_chk));
        if (cur_ck) last_chk = exp_chk;
        stop = 1'b1;
      end
      if (err) begin
        err_cyc = cyc;
        stop = 1'b1;
      end
      @(posedge clk);
      if (hs) wi++;
      if (fin) hdr_busy = 1'b0;
    end
    in_valid = 1'b0; hp_finished = 1'b0; blk_ready = 1'b0; pay_ready = 1'b0;
    check_eq("frame_ended", 64'(stop), 64'd1);
    if (exp_err == 0) begin
      check_eq("done_seen", 64'(done_seen), 64'd1);
      check_eq("no_err", 64'(err), 64'd0);
      check_eq("words_used", 64'(wi), 64'(nwords));
      check_eq("desc_left", 64'(exp_desc.size()), 64'd0);
      check_eq("pay_left", 64'(exp_pay.size()), 64'd0);
      check_eq("hp_start_cnt", 64'(hs_cnt), 64'd1);
      @(negedge clk);
      check_eq("done_pulse", 64'(frame_done), 64'd0);
    end else begin
      check_eq("err", 64'(err), 64'd1);
      check_eq("err_code", 64'(err_code), 64'(exp_err));
      if (exp_err_cyc >= 0) check_eq("err_cycle", 64'(err_cyc), 64'(exp_err_cyc));
    end
  endtask

  task automatic check_err_quiet();
    @(negedge clk);
    in_valid = 1'b1; pay_ready = 1'b1; blk_ready = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      check_eq("err_in_ready", 64'(in_ready), 64'd0);
      check_eq("err_outs", 64'({blk_valid, pay_valid}), 64'd0);
      check_eq("err_sticky", 64'(err), 64'd1);
    end
    in_valid = 1'b0; pay_ready = 1'b0; blk_ready = 1'b0;
  endtask

  initial begin
    do_reset();
    #1;
    check_eq("rst_err", 64'({err, err_code}), 64'd0);
    check_eq("rst_ctl", 64'({in_ready, hp_start, blk_valid, pay_valid, frame_done, chk_valid}), 64'd0);
    check_eq("rst_chk", 64'(chk_value), 64'd0);

    // raw block AA BB CC, 6-byte header
    begin_frame(6, 1'b0); add_block(0, 3, 1'b1, 8'hAA, 8'h11); end_frame(32'd0, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);

    // odd header: extra byte is block header b0; RLE size 256
    begin_frame(9, 1'b0); add_block(1, 256, 1'b1, 8'h7E, 0); end_frame(32'd0, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);

    // two raw blocks then checksum 11 22 33 44
    begin_frame(10, 1'b1); add_block(0, 2, 1'b0, -1, 0); add_block(0, 1, 1'b1, -1, 0);
    end_frame(32'h44332211, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b1, -1);

    // 8-byte raw block with pay_ready toggling every cycle
    begin_frame(7, 1'b0); add_block(0, 8, 1'b1, -1, 0); end_frame(32'd0, 1'b0);
    run_frame(0, 1'b0, -1, 1'b0, 1'b1, 1'b0, -1);

    for (int f = 0; f < 16; f++) begin
      int hl, nb, t, sz;
      bit ck;
      hl = 6 + int'($urandom_range(12));
      ck = 1'($urandom_range(1));
      nb = 1 + int'($urandom_range(2));
      begin_frame(hl, ck);
      for (int b = 0; b < nb; b++) begin
        t = int'($urandom_range(2));
        sz = (t == 1) ? int'($urandom_range(300)) : int'($urandom_range(12));
        add_block(t, sz, b == nb - 1, -1, 0);
      end
      end_frame(32'd0, 1'b1);
      run_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b1, -1);
      repeat (2) @(negedge clk);
    end

    // reserved block type, then async reset mid-cycle
    begin_frame(6, 1'b0); add_block(3, 5, 1'b1, -1, 0); end_frame(32'd0, 1'b0);
    run_frame(2, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    check_err_quiet();
    @(negedge clk); #2 reset = 1'b1;
    #1;
    check_eq("async_rst_err", 64'({err, err_code}), 64'd0);
    @(negedge clk) reset = 1'b0;
    last_chk = 32'd0;
    @(negedge clk);

    // in_valid drop during header
    begin_frame(12, 1'b0); add_block(0, 1, 1'b1, -1, 0); end_frame(32'd0, 1'b0);
    run_frame(1, 1'b0, 1, 1'b0, 1'b0, 1'b0, -1);
    do_reset();

    // parser never finishes: error after HDR_TIMEOUT cycles in HDR
    begin_frame(18, 1'b0); add_block(0, 1, 1'b1, -1, 0); end_frame(32'd0, 1'b0);
    run_frame(5, 1'b1, -1, 1'b0, 1'b0, 1'b0, 33);
    do_reset();

    // parser finishes one word early: word-count mismatch
    begin_frame(6, 1'b0); add_block(0, 1, 1'b1, -1, 0); end_frame(32'd0, 1'b0);
    run_frame(4, 1'b0, -1, 1'b1, 1'b0, 1'b0, -1);
    do_reset();

    // Block_Size one above the limit
    begin_frame(8, 1'b0); add_block(0, 131073, 1'b1, -1, 0); end_frame(32'd0, 1'b0);
    run_frame(3, 1'b0, -1, 1'b0, 1'b0, 1'b0, -1);
    check_err_quiet();
    do_reset();

    // recovery after errors, with checksum
    begin_frame(11, 1'b1); add_block(2, 0, 1'b0, -1, 0); add_block(1, 40, 1'b1, -1, 0);
    end_frame(32'd0, 1'b1);
    run_frame(0, 1'b0, -1, 1'b0, 1'b0, 1'b1, -1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
